// File: rtl/multicycle_control_if.sv
// Control/status bundle between the multicycle control unit and its datapath.
// master = control unit, slave = datapath side.
interface multicycle_control_if #(
  parameter int COUNT_WIDTH = 32
);
  logic [5:0]             Opcode;
  logic [5:0]             Funct;
  logic                   Zero;
  logic                   MemReady;
  logic                   PCEn;
  logic                   IorD;
  logic                   MemRead;
  logic                   MemWrite;
  logic                   IRWrite;
  logic                   MemtoReg;
  logic                   RegDst;
  logic                   RegWrite;
  logic                   Jal;
  logic                   ALUSrcA;
  logic                   IllegalOp;
  logic [1:0]             ALUSrcB;
  logic [1:0]             PCSource;
  logic [2:0]             ALUOp;
  logic [3:0]             StateOut;
  logic [COUNT_WIDTH-1:0] InstrCount;

  modport master (
    input  Opcode, Funct, Zero, MemReady,
    output PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
           Jal, ALUSrcA, IllegalOp, ALUSrcB, PCSource, ALUOp, StateOut, InstrCount
  );

  modport slave (
    output Opcode, Funct, Zero, MemReady,
    input  PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
           Jal, ALUSrcA, IllegalOp, ALUSrcB, PCSource, ALUOp, StateOut, InstrCount
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS-style datapath with a retired-instruction counter.
// Define MULTICYCLE_JAL_JR_EN to enable the jal / jr instructions; otherwise they decode as illegal.
module multicycle_control #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    FETCH        = 4'd0,
    DECODE       = 4'd1,
    MEM_ADDR     = 4'd2,
    MEM_READ     = 4'd3,
    MEM_WB       = 4'd4,
    MEM_WRITE    = 4'd5,
    EXECUTE      = 4'd6,
    R_COMPLETE   = 4'd7,
    BRANCH       = 4'd8,
    JUMP         = 4'd9,
    IMM_EXEC     = 4'd10,
    IMM_COMPLETE = 4'd11,
    JR           = 4'd12,
    JAL          = 4'd13
  } state_t;

  state_t                 state_r;
  state_t                 next_s;
  logic [COUNT_WIDTH-1:0] count_r;
  logic                   retire_s;

  logic       pcen_s, iord_s, memread_s, memwrite_s, irwrite_s, memtoreg_s;
  logic       regdst_s, regwrite_s, jal_s, alusrca_s, illegal_s;
  logic [1:0] alusrcb_s, pcsource_s;
  logic [2:0] aluop_s;

  // State register and retired-instruction counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= FETCH;
      count_r <= {COUNT_WIDTH{1'b0}};
    end else begin
      state_r <= next_s;
      if (retire_s) begin
        count_r <= count_r + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        count_r <= count_r;
      end
    end
  end

  // Next-state and Moore outputs; PCEn/IRWrite also follow MemReady/Zero where the datapath needs it
  always_comb begin
    next_s     = FETCH;
    pcen_s     = 1'b0;
    iord_s     = 1'b0;
    memread_s  = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    memtoreg_s = 1'b0;
    regdst_s   = 1'b0;
    regwrite_s = 1'b0;
    jal_s      = 1'b0;
    alusrca_s  = 1'b0;
    illegal_s  = 1'b0;
    alusrcb_s  = 2'b00;
    pcsource_s = 2'b00;
    aluop_s    = 3'b000;
    case (state_r)
      FETCH: begin
        memread_s = 1'b1;
        alusrcb_s = 2'b01;
        if (bus.MemReady) begin
          irwrite_s = 1'b1;
          pcen_s    = 1'b1;
          next_s    = DECODE;
        end else begin
          next_s    = FETCH;
        end
      end
      DECODE: begin
        alusrcb_s = 2'b11;
        case (bus.Opcode)
          6'h23, 6'h2B: next_s = MEM_ADDR;
          6'h00: begin
            if (bus.Funct == 6'h08) begin
`ifdef MULTICYCLE_JAL_JR_EN
              next_s    = JR;
`else
              illegal_s = 1'b1;
              next_s    = FETCH;
`endif
            end else begin
              next_s = EXECUTE;
            end
          end
          6'h04, 6'h05: next_s = BRANCH;
          6'h02:        next_s = JUMP;
          6'h03: begin
`ifdef MULTICYCLE_JAL_JR_EN
            next_s    = JAL;
`else
            illegal_s = 1'b1;
            next_s    = FETCH;
`endif
          end
          6'h08, 6'h0C, 6'h0D, 6'h0F: next_s = IMM_EXEC;
          default: begin
            illegal_s = 1'b1;
            next_s    = FETCH;
          end
        endcase
      end
      MEM_ADDR: begin
        alusrca_s = 1'b1;
        alusrcb_s = 2'b10;
        case (bus.Opcode)
          6'h23:   next_s = MEM_READ;
          6'h2B:   next_s = MEM_WRITE;
          default: next_s = FETCH;
        endcase
      end
      MEM_READ: begin
        memread_s = 1'b1;
        iord_s    = 1'b1;
        if (bus.MemReady) begin
          next_s = MEM_WB;
        end else begin
          next_s = MEM_READ;
        end
      end
      MEM_WRITE: begin
        memwrite_s = 1'b1;
        iord_s     = 1'b1;
        if (bus.MemReady) begin
          next_s = FETCH;
        end else begin
          next_s = MEM_WRITE;
        end
      end
      MEM_WB: begin
        regwrite_s = 1'b1;
        memtoreg_s = 1'b1;
        next_s     = FETCH;
      end
      EXECUTE: begin
        alusrca_s = 1'b1;
        aluop_s   = 3'b111;
        next_s    = R_COMPLETE;
      end
      R_COMPLETE: begin
        regwrite_s = 1'b1;
        regdst_s   = 1'b1;
        next_s     = FETCH;
      end
      BRANCH: begin
        alusrca_s  = 1'b1;
        aluop_s    = 3'b001;
        pcsource_s = 2'b01;
        case (bus.Opcode)
          6'h04:   pcen_s = bus.Zero;
          6'h05:   pcen_s = ~bus.Zero;
          default: pcen_s = 1'b0;
        endcase
        next_s = FETCH;
      end
      JUMP: begin
        pcsource_s = 2'b10;
        pcen_s     = 1'b1;
        next_s     = FETCH;
      end
      IMM_EXEC: begin
        alusrca_s = 1'b1;
        alusrcb_s = 2'b10;
        case (bus.Opcode)
          6'h0C:   aluop_s = 3'b011;
          6'h0D:   aluop_s = 3'b010;
          6'h0F:   aluop_s = 3'b100;
          default: aluop_s = 3'b000;
        endcase
        next_s = IMM_COMPLETE;
      end
      IMM_COMPLETE: begin
        regwrite_s = 1'b1;
        next_s     = FETCH;
      end
`ifdef MULTICYCLE_JAL_JR_EN
      JR: begin
        pcsource_s = 2'b11;
        pcen_s     = 1'b1;
        next_s     = FETCH;
      end
      JAL: begin
        pcsource_s = 2'b10;
        pcen_s     = 1'b1;
        regwrite_s = 1'b1;
        jal_s      = 1'b1;
        next_s     = FETCH;
      end
`endif
      default: begin
        next_s = FETCH;
      end
    endcase
  end

  // Illegal-opcode returns leave from DECODE, so they never count as retired
  assign retire_s = (next_s == FETCH) && (state_r != FETCH) && (state_r != DECODE);

  assign bus.PCEn       = pcen_s;
  assign bus.IorD       = iord_s;
  assign bus.MemRead    = memread_s;
  assign bus.MemWrite   = memwrite_s;
  assign bus.IRWrite    = irwrite_s;
  assign bus.MemtoReg   = memtoreg_s;
  assign bus.RegDst     = regdst_s;
  assign bus.RegWrite   = regwrite_s;
  assign bus.Jal        = jal_s;
  assign bus.ALUSrcA    = alusrca_s;
  assign bus.IllegalOp  = illegal_s;
  assign bus.ALUSrcB    = alusrcb_s;
  assign bus.PCSource   = pcsource_s;
  assign bus.ALUOp      = aluop_s;
  assign bus.StateOut   = state_r;
  assign bus.InstrCount = count_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Table-driven bench for multicycle_control: a 32-bit-counter instance plus a
// 4-bit-counter instance sharing the same stimulus for the wrap test.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       memready;
  int         errors = 0;
  int         checks = 0;

  multicycle_control_if #(.COUNT_WIDTH(32)) bus  ();
  multicycle_control_if #(.COUNT_WIDTH(4))  bus4 ();

  assign bus.Opcode    = opcode;
  assign bus.Funct     = funct;
  assign bus.Zero      = zero;
  assign bus.MemReady  = memready;
  assign bus4.Opcode   = opcode;
  assign bus4.Funct    = funct;
  assign bus4.Zero     = zero;
  assign bus4.MemReady = memready;

  multicycle_control #(.COUNT_WIDTH(32)) dut  (.clk(clk), .reset(reset), .bus(bus));
  multicycle_control #(.COUNT_WIDTH(4))  dut4 (.clk(clk), .reset(reset), .bus(bus4));

  always #5 clk = ~clk;

  // ctl bit order: PCEn IorD MemRead MemWrite IRWrite MemtoReg RegDst RegWrite Jal ALUSrcA IllegalOp | ALUSrcB | PCSource | ALUOp
  localparam logic [17:0] C_FETCH_W = 18'b0_0_1_0_0_0_0_0_0_0_0_01_00_000;
  localparam logic [17:0] C_FETCH_R = 18'b1_0_1_0_1_0_0_0_0_0_0_01_00_000;
  localparam logic [17:0] C_DECODE  = 18'b0_0_0_0_0_0_0_0_0_0_0_11_00_000;
  localparam logic [17:0] C_DEC_ILL = 18'b0_0_0_0_0_0_0_0_0_0_1_11_00_000;
  localparam logic [17:0] C_MADDR   = 18'b0_0_0_0_0_0_0_0_0_1_0_10_00_000;
  localparam logic [17:0] C_MREAD   = 18'b0_1_1_0_0_0_0_0_0_0_0_00_00_000;
  localparam logic [17:0] C_MWRITE  = 18'b0_1_0_1_0_0_0_0_0_0_0_00_00_000;
  localparam logic [17:0] C_MWB     = 18'b0_0_0_0_0_1_0_1_0_0_0_00_00_000;
  localparam logic [17:0] C_EXEC    = 18'b0_0_0_0_0_0_0_0_0_1_0_00_00_111;
  localparam logic [17:0] C_RCOMP   = 18'b0_0_0_0_0_0_1_1_0_0_0_00_00_000;
  localparam logic [17:0] C_BR_T    = 18'b1_0_0_0_0_0_0_0_0_1_0_00_01_001;
  localparam logic [17:0] C_BR_N    = 18'b0_0_0_0_0_0_0_0_0_1_0_00_01_001;
  localparam logic [17:0] C_JUMP    = 18'b1_0_0_0_0_0_0_0_0_0_0_00_10_000;
  localparam logic [17:0] C_IMM_ADD = 18'b0_0_0_0_0_0_0_0_0_1_0_10_00_000;
  localparam logic [17:0] C_IMM_AND = 18'b0_0_0_0_0_0_0_0_0_1_0_10_00_011;
  localparam logic [17:0] C_IMM_OR  = 18'b0_0_0_0_0_0_0_0_0_1_0_10_00_010;
  localparam logic [17:0] C_IMM_LUI = 18'b0_0_0_0_0_0_0_0_0_1_0_10_00_100;
  localparam logic [17:0] C_IMMC    = 18'b0_0_0_0_0_0_0_1_0_0_0_00_00_000;
`ifdef MULTICYCLE_JAL_JR_EN
  localparam logic [17:0] C_JAL     = 18'b1_0_0_0_0_0_0_1_1_0_0_00_10_000;
  localparam logic [17:0] C_JR      = 18'b1_0_0_0_0_0_0_0_0_0_0_00_11_000;
  localparam int JJ = 1;
`else
  localparam int JJ = 0;
`endif

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        rdy;
    logic [3:0]  st;
    logic [17:0] ctl;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                              input logic z, input logic rdy, input logic [3:0] st,
                              input logic [17:0] ctl, input logic [31:0] cnt);
    vec_t v;
    v.rst = rst; v.op = op; v.fn = fn; v.z = z; v.rdy = rdy;
    v.st = st; v.ctl = ctl; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  // Drive one cycle's inputs mid-cycle, then compare the outputs seen before the next edge
  task automatic apply(input vec_t v, input string tag);
    logic [17:0] ctl_got;
    @(negedge clk);
    reset    = v.rst;
    opcode   = v.op;
    funct    = v.fn;
    zero     = v.z;
    memready = v.rdy;
    #1;
    ctl_got = {bus.PCEn, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.MemtoReg,
               bus.RegDst, bus.RegWrite, bus.Jal, bus.ALUSrcA, bus.IllegalOp,
               bus.ALUSrcB, bus.PCSource, bus.ALUOp};
    chk({tag, " state"}, {28'd0, bus.StateOut}, {28'd0, v.st});
    chk({tag, " ctl"}, {14'd0, ctl_got}, {14'd0, v.ctl});
    chk({tag, " count"}, bus.InstrCount, v.cnt);
  endtask

  initial begin
    reset = 1'b1; opcode = 6'h00; funct = 6'h00; zero = 1'b0; memready = 1'b0;
    repeat (3) @(posedge clk);

    // lw, MemReady high throughout
    tbl.push_back(mk(1'b0, 6'h23, 6'h00, 1'b0, 1'b1, 4'd0, C_FETCH_R, 32'd0));
    tbl.push_back(mk(1'b0, 6'h23, 6'h00, 1'b0, 1'b1, 4'd1, C_DECODE,  32'd0));
    tbl.push_back(mk(1'b0, 6'h23, 6'h00, 1'b0, 1'b1, 4'd2, C_MADDR,   32'd0));
    tbl.push_back(mk(1'b0, 6'h23, 6'h00, 1'b0, 1'b1, 4'd3, C_MREAD,   32'd0));
    tbl.push_back(mk(1'b0, 6'h23, 6'h00, 1'b0, 1'b1, 4'd4, C_MWB,     32'd0));
    // sw, MemReady low for three cycles in MEM_WRITE
    tbl.push_back(mk(1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, 4'd0, C_FETCH_R, 32'd1));
    tbl.push_back(mk(1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, 4'd1, C_DECODE,  32'd1));
    tbl.push_back(mk(1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, 4'd2, C_MADDR,   32'd1));
    tbl.push_back(mk(1'b0, 6'h2B, 6'h00, 1'b0, 1'b0, 4'd5, C_MWRITE,  32'd1));
    tbl.push_back(mk(1'b0, 6'h2B, 6'h00, 1'b0, 1'b0, 4'd5, C_MWRITE,  32'd1));
    tbl.push_back(mk(1'b0, 6'h2B, 6'h00, 1'b0, 1'b0, 4'd5, C_MWRITE,  32'd1));
    tbl.push_back(mk(1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, 4'd5, C_MWRITE,  32'd1));
    // beq taken, then bne not taken, both with Zero=1
    tbl.push_back(mk(1'b0, 6'h04, 6'h00, 1'b1, 1'b1, 4'd0, C_FETCH_R, 32'd2));
    tbl.push_back(mk(1'b0, 6'h04, 6'h00, 1'b1, 1'b1, 4'd1, C_DECODE,  32'd2));
    tbl.push_back(mk(1'b0, 6'h04, 6'h00, 1'b1, 1'b1, 4'd8, C_BR_T,    32'd2));
    tbl.push_back(mk(1'b0, 6'h05, 6'h00, 1'b1, 1'b1, 4'd0, C_FETCH_R, 32'd3));
    tbl.push_back(mk(1'b0, 6'h05, 6'h00, 1'b1, 1'b1, 4'd1, C_DECODE,  32'd3));
    tbl.push_back(mk(1'b0, 6'h05, 6'h00, 1'b1, 1'b1, 4'd8, C_BR_N,    32'd3));
    // fetch wait, then illegal opcode 0x3F
    tbl.push_back(mk(1'b0, 6'h3F, 6'h00, 1'b0, 1'b0, 4'd0, C_FETCH_W, 32'd4));
    tbl.push_back(mk(1'b0, 6'h3F, 6'h00, 1'b0, 1'b1, 4'd0, C_FETCH_R, 32'd4));
    tbl.push_back(mk(1'b0, 6'h3F, 6'h00, 1'b0, 1'b1, 4'd1, C_DEC_ILL, 32'd4));
    // R-type add
    tbl.push_back(mk(1'b0, 6'h00, 6'h20, 1'b0, 1'b1, 4'd0, C_FETCH_R, 32'd4));
    tbl.push_back(mk(1'b0, 6'h00, 6'h20, 1'b0, 1'b1, 4'd1, C_DECODE,  32'd4));
    tbl.push_back(mk(1'b0, 6'h00, 6'h20, 1'b0, 1'b1, 4'd6, C_EXEC,    32'd4));
    tbl.push_back(mk(1'b0, 6'h00, 6'h20, 1'b0, 1'b1, 4'd7, C_RCOMP,   32'd4));
    // j
    tbl.push_back(mk(1'b0, 6'h02, 6'h00, 1'b0, 1'b1, 4'd0, C_FETCH_R, 32'd5));
    tbl.push_back(mk(1'b0, 6'h02, 6'h00, 1'b0, 1'b1, 4'd1, C_DECODE,  32'd5));
    tbl.push_back(mk(1'b0, 6'h02, 6'h00, 1'b0, 1'b1, 4'd9, C_JUMP,    32'd5));
    // andi, lui, ori, addi
    tbl.push_back(mk(1'b0, 6'h0C, 6'h00, 1'b0, 1'b1, 4'd0,  C_FETCH_R, 32'd6));
    tbl.push_back(mk(1'b0, 6'h0C, 6'h00, 1'b0, 1'b1, 4'd1,  C_DECODE,  32'd6));
    tbl.push_back(mk(1'b0, 6'h0C, 6'h00, 1'b0, 1'b1, 4'd10, C_IMM_AND, 32'd6));
    tbl.push_back(mk(1'b0, 6'h0C, 6'h00, 1'b0, 1'b1, 4'd11, C_IMMC,    32'd6));
    tbl.push_back(mk(1'b0, 6'h0F, 6'h00, 1'b0, 1'b1, 4'd0,  C_FETCH_R, 32'd7));
    tbl.push_back(mk(1'b0, 6'h0F, 6'h00, 1'b0, 1'b1, 4'd1,  C_DECODE,  32'd7));
    tbl.push_back(mk(1'b0, 6'h0F, 6'h00, 1'b0, 1'b1, 4'd10, C_IMM_LUI, 32'd7));
    tbl.push_back(mk(1'b0, 6'h0F, 6'h00, 1'b0, 1'b1, 4'd11, C_IMMC,    32'd7));
    tbl.push_back(mk(1'b0, 6'h0D, 6'h00, 1'b0, 1'b1, 4'd0,  C_FETCH_R, 32'd8));
    tbl.push_back(mk(1'b0, 6'h0D, 6'h00, 1'b0, 1'b1, 4'd1,  C_DECODE,  32'd8));
    tbl.push_back(mk(1'b0, 6'h0D, 6'h00, 1'b0, 1'b1, 4'd10, C_IMM_OR,  32'd8));
    tbl.push_back(mk(1'b0, 6'h0D, 6'h00, 1'b0, 1'b1, 4'd11, C_IMMC,    32'd8));
    tbl.push_back(mk(1'b0, 6'h08, 6'h00, 1'b0, 1'b1, 4'd0,  C_FETCH_R, 32'd9));
    tbl.push_back(mk(1'b0, 6'h08, 6'h00, 1'b0, 1'b1, 4'd1,  C_DECODE,  32'd9));
    tbl.push_back(mk(1'b0, 6'h08, 6'h00, 1'b0, 1'b1, 4'd10, C_IMM_ADD, 32'd9));
    tbl.push_back(mk(1'b0, 6'h08, 6'h00, 1'b0, 1'b1, 4'd11, C_IMMC,    32'd9));

    foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));

    // jal, then jr: real instructions with the macro, illegal opcodes without
    apply(mk(1'b0, 6'h03, 6'h00, 1'b0, 1'b1, 4'd0, C_FETCH_R, 32'd10), "jal fetch");
`ifdef MULTICYCLE_JAL_JR_EN
    apply(mk(1'b0, 6'h03, 6'h00, 1'b0, 1'b1, 4'd1,  C_DECODE,  32'd10), "jal decode");
    apply(mk(1'b0, 6'h03, 6'h00, 1'b0, 1'b1, 4'd13, C_JAL,     32'd10), "jal exec");
    apply(mk(1'b0, 6'h00, 6'h08, 1'b0, 1'b1, 4'd0,  C_FETCH_R, 32'd11), "jr fetch");
    apply(mk(1'b0, 6'h00, 6'h08, 1'b0, 1'b1, 4'd1,  C_DECODE,  32'd11), "jr decode");
    apply(mk(1'b0, 6'h00, 6'h08, 1'b0, 1'b1, 4'd12, C_JR,      32'd11), "jr exec");
`else
    apply(mk(1'b0, 6'h03, 6'h00, 1'b0, 1'b1, 4'd1,  C_DEC_ILL, 32'd10), "jal illegal");
    apply(mk(1'b0, 6'h00, 6'h08, 1'b0, 1'b1, 4'd0,  C_FETCH_R, 32'd10), "jr fetch");
    apply(mk(1'b0, 6'h00, 6'h08, 1'b0, 1'b1, 4'd1,  C_DEC_ILL, 32'd10), "jr illegal");
`endif

    // reset while MEM_READ waits on MemReady
    apply(mk(1'b0, 6'h23, 6'h00, 1'b0, 1'b1, 4'd0, C_FETCH_R, 32'(10 + 2 * JJ)), "rst fetch");
    apply(mk(1'b0, 6'h23, 6'h00, 1'b0, 1'b1, 4'd1, C_DECODE,  32'(10 + 2 * JJ)), "rst decode");
    apply(mk(1'b0, 6'h23, 6'h00, 1'b0, 1'b1, 4'd2, C_MADDR,   32'(10 + 2 * JJ)), "rst maddr");
    apply(mk(1'b0, 6'h23, 6'h00, 1'b0, 1'b0, 4'd3, C_MREAD,   32'(10 + 2 * JJ)), "rst wait");
    apply(mk(1'b1, 6'h23, 6'h00, 1'b0, 1'b0, 4'd3, C_MREAD,   32'(10 + 2 * JJ)), "rst assert");
    apply(mk(1'b0, 6'h23, 6'h00, 1'b0, 1'b0, 4'd0, C_FETCH_W, 32'd0), "rst after");
    chk("rst count4", {28'd0, bus4.InstrCount}, 32'd0);

    // 16 adds: the 4-bit counter reaches 15 and then wraps to 0
    for (int i = 0; i < 16; i++) begin
      apply(mk(1'b0, 6'h00, 6'h20, 1'b0, 1'b1, 4'd0, C_FETCH_R, 32'(i)), $sformatf("add%0d fetch", i));
      chk($sformatf("add%0d count4", i), {28'd0, bus4.InstrCount}, 32'(i));
      apply(mk(1'b0, 6'h00, 6'h20, 1'b0, 1'b1, 4'd1, C_DECODE, 32'(i)), $sformatf("add%0d decode", i));
      apply(mk(1'b0, 6'h00, 6'h20, 1'b0, 1'b1, 4'd6, C_EXEC,   32'(i)), $sformatf("add%0d exec", i));
      apply(mk(1'b0, 6'h00, 6'h20, 1'b0, 1'b1, 4'd7, C_RCOMP,  32'(i)), $sformatf("add%0d rcomp", i));
    end
    apply(mk(1'b0, 6'h00, 6'h20, 1'b0, 1'b0, 4'd0, C_FETCH_W, 32'd16), "wrap fetch");
    chk("wrap count4", {28'd0, bus4.InstrCount}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
